// File: rtl/mt_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : mt_regfile_if
// Brief    : ID read / WB write / clear-request bundle for the threaded regfile.
// Revision : 1.0  initial release
// ============================================================================
interface mt_regfile_if #(
    parameter int D_WIDTH = 64,
    parameter int TID_W   = 2
);
    logic               rd_en_ID;
    logic [TID_W-1:0]   thread_ID;
    logic [4:0]         rs1_ID;
    logic [4:0]         rs2_ID;
    logic [D_WIDTH-1:0] reg1data;
    logic [D_WIDTH-1:0] reg2data;
    logic               rd_valid;
    logic               ctrl_WB;
    logic [TID_W-1:0]   thread_WB;
    logic [4:0]         reg_wraddr;
    logic [D_WIDTH-1:0] data_WB;
    logic               clr_req;
    logic [TID_W-1:0]   clr_thread;
    logic               clr_busy;
    logic               clr_done;

    modport master (
        output rd_en_ID, thread_ID, rs1_ID, rs2_ID,
        output ctrl_WB, thread_WB, reg_wraddr, data_WB,
        output clr_req, clr_thread,
        input  reg1data, reg2data, rd_valid, clr_busy, clr_done
    );

    modport slave (
        input  rd_en_ID, thread_ID, rs1_ID, rs2_ID,
        input  ctrl_WB, thread_WB, reg_wraddr, data_WB,
        input  clr_req, clr_thread,
        output reg1data, reg2data, rd_valid, clr_busy, clr_done
    );
endinterface
`default_nettype wire

// File: rtl/mt_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mt_regfile
// Brief    : Per-thread 32 x D_WIDTH register file, 2R/1W, bypass, x0, clear.
// Revision : 1.0  initial release
// ============================================================================
module mt_regfile #(
    parameter int D_WIDTH     = 64,
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    mt_regfile_if.slave  bus
);
    localparam logic [1:0]     c_ST_IDLE  = 2'd0;
    localparam logic [1:0]     c_ST_CLEAR = 2'd1;
    localparam logic [1:0]     c_ST_DONE  = 2'd2;
    localparam logic [TID_W:0] c_NUM_T    = (TID_W+1)'(NUM_THREADS);

    logic [D_WIDTH-1:0] r_mem [NUM_THREADS][32];

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [TID_W-1:0]   r_ct;
    logic [4:0]         r_idx;

    logic               w_rd_legal;
    logic               w_wb_legal;
    logic               w_clr_legal;
    logic               w_clearing;
    logic               w_clr_accept;
    logic               w_clr_we;
    logic               w_wb_we;
    logic               w_rd_blocked;
    logic               w_byp1;
    logic               w_byp2;
    logic [D_WIDTH-1:0] w_rd1;
    logic [D_WIDTH-1:0] w_rd2;
    logic [D_WIDTH-1:0] r_rd1;
    logic [D_WIDTH-1:0] r_rd2;
    logic               r_rd_valid;

    assign w_rd_legal   = {1'b0, bus.thread_ID}  < c_NUM_T;
    assign w_wb_legal   = {1'b0, bus.thread_WB}  < c_NUM_T;
    assign w_clr_legal  = {1'b0, bus.clr_thread} < c_NUM_T;
    assign w_clearing   = (r_state != c_ST_IDLE);
    assign w_clr_accept = (r_state == c_ST_IDLE) && bus.clr_req && w_clr_legal;
    assign w_clr_we     = (r_state == c_ST_CLEAR);

    // The thread being cleared is fenced off from WB and ID until DONE has passed
    assign w_wb_we      = bus.ctrl_WB && w_wb_legal && (bus.reg_wraddr != 5'd0)
                          && !(w_clearing && (bus.thread_WB == r_ct));
    assign w_rd_blocked = !w_rd_legal || (w_clearing && (bus.thread_ID == r_ct));

    assign w_byp1 = bus.ctrl_WB && (bus.thread_WB == bus.thread_ID)
                    && (bus.reg_wraddr == bus.rs1_ID);
    assign w_byp2 = bus.ctrl_WB && (bus.thread_WB == bus.thread_ID)
                    && (bus.reg_wraddr == bus.rs2_ID);

    always_ff @(posedge clk) begin
        if (w_wb_we) begin
            r_mem[bus.thread_WB][bus.reg_wraddr] <= bus.data_WB;
        end
        if (w_clr_we) begin
            r_mem[r_ct][r_idx] <= '0;
        end
    end

    always_comb begin
        w_rd1 = r_mem[bus.thread_ID][bus.rs1_ID];
        if (w_rd_blocked || (bus.rs1_ID == 5'd0)) begin
            w_rd1 = '0;
        end else if (w_byp1) begin
            w_rd1 = bus.data_WB;
        end
    end

    always_comb begin
        w_rd2 = r_mem[bus.thread_ID][bus.rs2_ID];
        if (w_rd_blocked || (bus.rs2_ID == 5'd0)) begin
            w_rd2 = '0;
        end else if (w_byp2) begin
            w_rd2 = bus.data_WB;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en_ID;
            if (bus.rd_en_ID) begin
                r_rd1 <= w_rd1;
                r_rd2 <= w_rd2;
            end
        end
    end

    assign bus.reg1data = r_rd1;
    assign bus.reg2data = r_rd2;
    assign bus.rd_valid = r_rd_valid;

    // Clear sequencer: x0 is never stored, so the walk covers indices 1..31
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_ct    <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr_accept) begin
                r_ct  <= bus.clr_thread;
                r_idx <= 5'd1;
            end else if (w_clr_we) begin
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_clr_accept) w_state_nxt = c_ST_CLEAR;
            c_ST_CLEAR: if (r_idx == 5'd31) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        bus.clr_busy = (r_state == c_ST_CLEAR);
        bus.clr_done = (r_state == c_ST_DONE);
    end
endmodule
`default_nettype wire

// File: doc/mt_regfile.md
Name: mt_regfile

Overview:
Parametrised multi-threaded integer register file for the barrel-threaded RISC-V core. It holds one 32-entry architectural register set per hardware thread, selected by binary thread ID. It serves two read ports in ID with one-cycle registered latency and one write port from WB. It adds write-to-read bypass, hardwired x0, and a per-thread hardware clear sequencer used on thread (re)launch. It sits between the ID and WB pipeline stages.

Parameters:
D_WIDTH, 64, register data width in bits
NUM_THREADS, 4, number of hardware threads / register sets (>=1, need not be a power of 2)
TID_W, $clog2(NUM_THREADS) (min 1), width of thread ID fields

Ports:
clk  input  1  core clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
rd_en_ID  input  1  read request this cycle
thread_ID  input  TID_W  thread of the read
rs1_ID  input  5  source register 1 index
rs2_ID  input  5  source register 2 index
reg1data  output  D_WIDTH  rs1 value, registered
reg2data  output  D_WIDTH  rs2 value, registered
rd_valid  output  1  reg1data/reg2data valid (rd_en_ID delayed 1 cycle)
ctrl_WB  input  1  write enable from WB
thread_WB  input  TID_W  thread of the write
reg_wraddr  input  5  destination register index
data_WB  input  D_WIDTH  write data
clr_req  input  1  single-cycle request to zero a thread's register set
clr_thread  input  TID_W  thread to clear, sampled with clr_req
clr_busy  output  1  clear sequence in progress
clr_done  output  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (async, reset_n=0): reg1data=0, reg2data=0, rd_valid=0, clr_busy=0, clr_done=0, FSM=IDLE, clear index=0. Storage array is not reset; its contents are undefined until written or cleared.
- Storage: NUM_THREADS x 32 x D_WIDTH flops. Entry (t,r) is addressed by thread t and register r.
- Read: when rd_en_ID=1 at edge N, the values appear on reg1data/reg2data with rd_valid=1 after edge N. This is a 1-cycle latency. When rd_en_ID=0, the outputs hold their previous value and rd_valid=0.
- x0: a read of index 0 returns 0. A write to index 0 is dropped.
- Bypass (write-first): if ctrl_WB=1 and thread_WB==thread_ID and reg_wraddr==rsX_ID!=0 in the same cycle, that port returns data_WB. Both ports may bypass at once.
- Write: ctrl_WB=1 updates entry (thread_WB, reg_wraddr) at the edge.
- Out-of-range thread ID (>=NUM_THREADS): reads return 0, writes are dropped, and clr_req is ignored.
- Clear FSM, states IDLE -> CLEAR -> DONE -> IDLE:
  - IDLE: clr_req=1 with a legal clr_thread latches the thread (ct), sets index=1, and goes to CLEAR. clr_busy rises the next cycle.
  - CLEAR: zeroes (ct, index) each cycle and increments index. After writing index 31 it goes to DONE. Entries 1..31 are written, so CLEAR lasts 31 cycles.
  - DONE: clr_done=1 and clr_busy=0 for one cycle, then IDLE.
  - clr_busy=1 in CLEAR only.
  - clr_req is ignored unless the FSM is in IDLE.
- Interaction during CLEAR/DONE (ct = the thread being cleared):
  - WB writes to ct are dropped.
  - Reads of ct return 0, and bypass is not applied for ct.
  - Reads and writes of other threads proceed normally and concurrently.
- In the same cycle as clr_req is accepted, a WB write or read to that thread still behaves as in IDLE.
- Reset mid-clear: the FSM aborts to IDLE and no clr_done is issued. Partially cleared contents remain; software must re-request the clear.

Test Plan:
- Write t2 x5=0xDEAD_BEEF_0000_0001, then next cycle read t2 rs1=5, rs2=0 -> after 1 cycle reg1data=0xDEADBEEF00000001, reg2data=0, rd_valid=1; read of t0 x5 differs (no aliasing).
- Same cycle: ctrl_WB t1 x7=0x1234 and read t1 rs1=7, rs2=7 -> both outputs 0x1234 next cycle. The same case with thread_ID=0 returns the old t0 x7.
- Write t3 x0=0xFF, then read t3 x0 -> 0.
- Preload t1 x1..x31 with index values, pulse clr_req clr_thread=1 -> clr_busy high 31 cycles, then clr_done pulse. All t1 reads return 0. Concurrent t0 write/read of x9=0x55 succeeds. WB write to t1 during CLEAR is dropped. A second clr_req mid-sequence is ignored.
- NUM_THREADS=3 build: read/write thread_ID=3 -> outputs 0, no state change. clr_req thread 3 -> clr_busy stays 0.
- Assert reset_n low at CLEAR cycle 10 -> outputs and clr_busy go 0 immediately. No clr_done is issued. A new clr_req completes normally after reset is released.
